nibble_in_port: RTL and testbench

NIBBLE_IN_PORT -- requirements
Module: nibble_in_port

---
 rtl/nibbler_io_pkg.sv | 15 +
 rtl/nibble_sync2.sv | 27 ++
 rtl/nibble_in_port.sv | 137 +++++++++++++
 tb/tb_nibble_in_port.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibbler_io_pkg
// Purpose  : Shared nibble type and default sizing for the nibbler I/O ports.
// Revision : 1.0 - initial release
// ============================================================================
package nibbler_io_pkg;

    typedef logic [3:0] nibble_t;

    localparam int c_DEFAULT_WIDTH = 4;
    localparam int c_DEFAULT_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/nibble_sync2.sv
`default_nettype none
// ============================================================================
// Module   : nibble_sync2
// Purpose  : Two-flop synchronizer for a single asynchronous control bit.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], d};
        end
    end

    assign q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/nibble_in_port.sv
`default_nettype none
// ============================================================================
// Module   : nibble_in_port
// Purpose  : Strobe-driven input FIFO feeding the CPU IN instruction.
//            Define NIBBLE_IN_SYNC_EN to pass ext_stb through nibble_sync2.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_in_port
    import nibbler_io_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ext_stb,
    input  logic [WIDTH-1:0]       ext_data,
    input  logic                   rd_en,
    input  logic                   clr_ovf,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic              w_stb_now;
    logic              w_stb_valid;
    logic              r_stb_prev;
    logic              r_armed;
    logic              w_push;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_drop;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   w_count_nxt;
    logic              r_empty;
    logic              r_full;
    logic              r_ovf;
    logic [WIDTH-1:0]  r_mem [DEPTH];

`ifdef NIBBLE_IN_SYNC_EN
    logic [1:0] r_fill;

    nibble_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ext_stb),
        .q     (w_stb_now)
    );

    // Synchronizer output only reflects a real sample once both stages refilled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill <= 2'b00;
        end else begin
            r_fill <= {r_fill[0], 1'b1};
        end
    end

    assign w_stb_valid = r_fill[1];
`else
    assign w_stb_now   = ext_stb;
    assign w_stb_valid = 1'b1;
`endif

    // Edge detection only arms after the strobe is seen low, so a strobe held
    // high across reset release cannot masquerade as a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stb_prev <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_stb_prev <= w_stb_now;
            r_armed    <= r_armed | (w_stb_valid & ~w_stb_now);
        end
    end

    assign w_push    = w_stb_now & ~r_stb_prev & r_armed;
    assign w_pop     = rd_en & ~r_empty;
    assign w_push_ok = w_push & (~r_full | w_pop);
    assign w_drop    = w_push & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + c_CW'(1);
            2'b01:   w_count_nxt = r_count - c_CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_CW'(DEPTH));
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= ext_data;
        end
    end

    assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign empty    = r_empty;
    assign full     = r_full;
    assign count    = r_count;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_in_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_in_port
// Purpose  : Self-checking bench for nibble_in_port against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_in_port;
    import nibbler_io_pkg::*;

`ifdef NIBBLE_IN_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 0;
`endif
    localparam int c_DEPTH = 4;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       ext_stb  = 1'b0;
    nibble_t    ext_data = '0;
    logic       rd_en    = 1'b0;
    logic       clr_ovf  = 1'b0;
    nibble_t    rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Reference: FIFO contents, overflow flag, strobe history per edge
    // (h[0] newest). Pre-reset history counts as high, so no edge exists.
    nibble_t m_q[$];
    bit      m_ovf;
    bit      h [4];

    always #5 clk = ~clk;

    nibble_in_port #(.WIDTH(4), .DEPTH(c_DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .ext_stb  (ext_stb),
        .ext_data (ext_data),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        for (int i = 0; i < 4; i++) h[i] = 1'b1;
    endtask

    task automatic tick();
        bit push, pop, drop;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = ext_stb;
            push = h[c_LAT] && !h[c_LAT+1];
            pop  = rd_en && (m_q.size() > 0);
            drop = push && (m_q.size() == c_DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (push && !drop) m_q.push_back(ext_data);
            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic pulse(input nibble_t d, input int width);
        ext_data = d;
        ext_stb  = 1'b1;
        repeat (width) tick();
        ext_stb = 1'b0;
        repeat (c_LAT + 1) tick();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || rd_data !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: empty=%b full=%b count=%0d ovf=%b rd=%h, expected 1 0 0 0 0",
                     empty, full, count, overflow, rd_data);
        end
        tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_push();
        int n = 0;
        ext_data = 4'hA;
        ext_stb  = 1'b1;
        do begin
            tick();
            ext_stb = 1'b0;
            n++;
        end while (empty && n < 8);
        checks++;
        if (n !== c_LAT + 1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL push_latency: edges=%0d empty=%b, expected edges=%0d empty=0", n, empty, c_LAT + 1);
        end
        checks++;
        if (rd_data !== 4'hA || count !== 3'd1) begin
            failures++;
            $display("FAIL single_push: rd=%h count=%0d, expected A 1", rd_data, count);
        end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || rd_data !== 4'h0) begin
            failures++;
            $display("FAIL single_pop: empty=%b rd=%h, expected 1 0", empty, rd_data);
        end
        repeat (c_LAT + 1) tick();
    endtask

    task automatic test_fill_overflow();
        nibble_t exp_seq [4] = '{4'h5, 4'h6, 4'h7, 4'h8};
        for (int i = 0; i < 4; i++) pulse(exp_seq[i], 1);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill: full=%b count=%0d ovf=%b, expected 1 4 0", full, count, overflow);
        end
        pulse(4'h9, 1);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            failures++;
            $display("FAIL overflow_set: ovf=%b count=%0d, expected 1 4", overflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data !== exp_seq[i]) begin
                failures++;
                $display("FAIL drain_order[%0d]: rd=%h, expected %h", i, rd_data, exp_seq[i]);
            end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL drained: empty=%b ovf=%b, expected 1 1", empty, overflow);
        end
    endtask

    task automatic test_overflow_clear();
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b, expected 0", overflow);
        end
        for (int i = 0; i < 4; i++) pulse(nibble_t'($urandom), 1);
        ext_data = nibble_t'($urandom);
        ext_stb  = 1'b1;
        for (int k = 0; k <= c_LAT; k++) begin
            clr_ovf = (k == c_LAT);
            tick();
            ext_stb = 1'b0;
        end
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b1 || overflow !== m_ovf) begin
            failures++;
            $display("FAIL ovf_clear_collision: ovf=%b, expected 1", overflow);
        end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear_again: ovf=%b, expected 0", overflow);
        end
        while (m_q.size() > 0) begin
            checks++;
            if (rd_data !== m_q[0]) begin
                failures++;
                $display("FAIL ovf_drain: rd=%h, expected %h", rd_data, m_q[0]);
            end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
    endtask

    task automatic test_full_push_pop();
        nibble_t d = nibble_t'($urandom);
        for (int i = 0; i < 4; i++) pulse(nibble_t'($urandom), 1);
        ext_data = d;
        ext_stb  = 1'b1;
        for (int k = 0; k <= c_LAT; k++) begin
            rd_en = (k == c_LAT);
            tick();
            ext_stb = 1'b0;
        end
        rd_en = 1'b0;
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop: count=%0d full=%b ovf=%b, expected 4 1 0", count, full, overflow);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data !== m_q[0]) begin
                failures++;
                $display("FAIL full_pp_drain[%0d]: rd=%h, expected %h", i, rd_data, m_q[0]);
            end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        checks++;
        if (rd_data !== d || count !== 3'd1) begin
            failures++;
            $display("FAIL full_pp_newdata: rd=%h count=%0d, expected %h 1", rd_data, count, d);
        end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic test_empty_reads();
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 3'd0 || rd_data !== 4'h0 || empty !== 1'b1) begin
                failures++;
                $display("FAIL empty_read[%0d]: count=%0d rd=%h empty=%b, expected 0 0 1", i, count, rd_data, empty);
            end
        end
        rd_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nibble_t d = nibble_t'($urandom);
            pulse(d, 1);
            checks++;
            if (rd_data !== d || count !== 3'd1) begin
                failures++;
                $display("FAIL wrap_pair[%0d]: rd=%h count=%0d, expected %h 1", i, rd_data, count, d);
            end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_end: empty=%b, expected 1", empty);
        end
    endtask

    task automatic test_long_strobe();
        nibble_t d = nibble_t'($urandom);
        pulse(d, 10);
        checks++;
        if (count !== 3'd1 || rd_data !== d) begin
            failures++;
            $display("FAIL long_strobe: count=%0d rd=%h, expected 1 %h", count, rd_data, d);
        end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    task automatic test_random();
        int since_rise = 100;
        for (int c = 0; c < 400; c++) begin
            rd_en   = ($urandom_range(0, 9) < 3);
            clr_ovf = ($urandom_range(0, 15) == 0);
            if (ext_stb) begin
                ext_stb = ($urandom_range(0, 1) == 1);
            end else if (since_rise >= c_LAT + 2 && $urandom_range(0, 1) == 1) begin
                ext_stb    = 1'b1;
                ext_data   = nibble_t'($urandom);
                since_rise = 0;
            end
            tick();
            since_rise++;
            checks++;
            if (count !== 3'(m_q.size()) || empty !== (m_q.size() == 0) || full !== (m_q.size() == c_DEPTH)
                || overflow !== m_ovf || rd_data !== ((m_q.size() > 0) ? m_q[0] : 4'h0)) begin
                failures++;
                $display("FAIL random[%0d]: count=%0d empty=%b full=%b ovf=%b rd=%h, expected count=%0d ovf=%b rd=%h",
                         c, count, empty, full, overflow, rd_data, m_q.size(), m_ovf,
                         (m_q.size() > 0) ? m_q[0] : 4'h0);
            end
        end
        rd_en = 1'b0; clr_ovf = 1'b0; ext_stb = 1'b0;
        repeat (c_LAT + 2) tick();
    endtask

    task automatic test_reset_mid();
        while (m_q.size() > 0) begin
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        for (int i = 0; i < 3; i++) pulse(nibble_t'($urandom), 1);
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset_count: count=%0d, expected 3", count);
        end
        ext_data = nibble_t'($urandom);
        ext_stb  = 1'b1;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || count !== 3'd0 || rd_data !== 4'h0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: empty=%b count=%0d rd=%h ovf=%b, expected 1 0 0 0", empty, count, rd_data, overflow);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        ext_stb = 1'b0;
        repeat (c_LAT + 2) tick();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL stb_across_reset: count=%0d empty=%b, expected 0 1", count, empty);
        end
        pulse(4'h3, 1);
        checks++;
        if (count !== 3'd1 || rd_data !== 4'h3) begin
            failures++;
            $display("FAIL post_reset_push: count=%0d rd=%h, expected 1 3", count, rd_data);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_overflow_clear();
        test_full_push_pop();
        test_empty_reads();
        test_long_strobe();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
